// File: rtl/irq_priority_arbiter_if.sv
// rtl/irq_priority_arbiter_if.sv - request/grant bundle between request sources, arbiter and consumer
//
// Purpose: groups the request, mask and grant handshake signals of irq_priority_arbiter.
// Ports (signals):
//   req     [N-1:0]  request lines, a 0->1 edge raises a request
//   mask    [N-1:0]  1 = line blocked from selection
//   ack              consumer accepts the current grant
//   valid            id holds a granted request
//   id      [W-1:0]  index of the granted request
//   pending [N-1:0]  registered sticky pending bits
// Modports: master = sources/consumer side, slave = arbiter side.
interface irq_priority_arbiter_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ack;
  logic         valid;
  logic [W-1:0] id;
  logic [N-1:0] pending;

  modport master (
    output req,
    output mask,
    output ack,
    input  valid,
    input  id,
    input  pending
  );

  modport slave (
    input  req,
    input  mask,
    input  ack,
    output valid,
    output id,
    output pending
  );
endinterface

// File: rtl/irq_priority_arbiter.sv
// rtl/irq_priority_arbiter.sv - edge-capturing priority arbiter with valid/ack grant handshake
//
// Purpose: captures rising edges on req into sticky pending bits and grants the
// highest-index unmasked pending line; the serviced bit is cleared on ack.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    irq_priority_arbiter_if.slave (req, mask, ack in; valid, id, pending out)
// All outputs come straight from registers.
module irq_priority_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  irq_priority_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] req_q;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] eligible;
  logic [W-1:0] id_q;
  logic [W-1:0] id_d;
  logic [W-1:0] top;

  assign rise     = bus.req & ~req_q;
  assign eligible = pending_q & ~mask_or_zero();
  // A fresh rise on the bit being cleared wins, so a re-request that lands on
  // the ack cycle is not lost.
  assign pending_d = (pending_q & ~clr) | rise;

  function automatic logic [N-1:0] mask_or_zero();
    return bus.mask;
  endfunction

  // Highest set bit of eligible; later iterations overwrite, so the top index wins.
  always_comb begin
    top = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) begin
        top = W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          id_d    = top;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // id stays frozen here; mask changes and new rises cannot retarget it.
        if (bus.ack) begin
          clr[id_q] = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req;
      pending_q <= pending_d;
      id_q      <= id_d;
    end
  end

  assign bus.valid   = (state_q == GRANT);
  assign bus.id      = id_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// tb/tb_irq_priority_arbiter.sv - self-checking bench for irq_priority_arbiter
`timescale 1ns/1ps
module tb_irq_priority_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic clk;
  logic rst_n;

  irq_priority_arbiter_if #(.N(N), .W(W)) bus ();

  irq_priority_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Expected outputs after the next active edge.
  bit [N-1:0] m_pending;
  bit [N-1:0] m_reqprev;
  bit         m_valid;
  bit [W-1:0] m_id;

  task automatic model_clear();
    m_pending = '0;
    m_reqprev = '0;
    m_valid   = 1'b0;
    m_id      = '0;
  endtask

  // Next state from the rules: rises set pending, ack of a live grant retires
  // that line unless it rose again, an idle arbiter grants the top eligible line.
  task automatic model_step();
    bit [N-1:0] nxt;
    int svc;
    int hi;
    if (!rst_n) begin
      model_clear();
      return;
    end
    svc = (m_valid && bus.ack) ? int'(m_id) : -1;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && !m_reqprev[i]) nxt[i] = 1'b1;
      else if (i == svc)               nxt[i] = 1'b0;
      else                             nxt[i] = m_pending[i];
    end
    if (m_valid) begin
      if (bus.ack) m_valid = 1'b0;
    end else begin
      hi = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (hi < 0 && m_pending[i] && !bus.mask[i]) hi = i;
      end
      if (hi >= 0) begin
        m_valid = 1'b1;
        m_id    = W'(hi);
      end
    end
    m_pending = nxt;
    m_reqprev = bus.req;
  endtask

  always @(posedge clk) begin
    #2;
    n_vec++;
    if (bus.valid !== m_valid || bus.id !== m_id || bus.pending !== m_pending) begin
      n_bad++;
      $display("FAIL model t=%0t: got valid=%0b id=%0d pending=%b, expected valid=%0b id=%0d pending=%b",
               $time, bus.valid, bus.id, bus.pending, m_valid, m_id, m_pending);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] m, input logic a);
    @(negedge clk);
    bus.req  = r;
    bus.mask = m;
    bus.ack  = a;
    model_step();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.mask = '0;
    bus.ack  = 1'b0;
    model_clear();
    #1;
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_id", int'(bus.id), 0);
    chk("reset_pending", int'(bus.pending), 0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    cycle(4'b0000, 4'b0000, 1'b0);

    // single request
    cycle(4'b0001, 4'b0000, 1'b0);
    chk("single_pending", int'(bus.pending), 4'b0001);
    chk("single_valid0", int'(bus.valid), 0);
    cycle(4'b0001, 4'b0000, 1'b0);
    chk("single_valid", int'(bus.valid), 1);
    chk("single_id", int'(bus.id), 0);
    cycle(4'b0001, 4'b0000, 1'b1);
    chk("single_ack_valid", int'(bus.valid), 0);
    chk("single_ack_pending", int'(bus.pending), 0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // simultaneous requests
    cycle(4'b0110, 4'b0000, 1'b0);
    chk("simul_pending", int'(bus.pending), 4'b0110);
    cycle(4'b0110, 4'b0000, 1'b0);
    chk("simul_first_id", int'(bus.id), 2);
    cycle(4'b0110, 4'b0000, 1'b1);
    chk("simul_idle_gap", int'(bus.valid), 0);
    chk("simul_pending_after1", int'(bus.pending), 4'b0010);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("simul_second_valid", int'(bus.valid), 1);
    chk("simul_second_id", int'(bus.id), 1);
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("simul_pending_after2", int'(bus.pending), 0);

    // ack while idle is ignored
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("idle_ack_valid", int'(bus.valid), 0);
    chk("idle_ack_pending", int'(bus.pending), 0);

    // mask
    cycle(4'b1001, 4'b1000, 1'b0);
    cycle(4'b1001, 4'b1000, 1'b0);
    chk("mask_id", int'(bus.id), 0);
    chk("mask_pending3", int'(bus.pending[3]), 1);
    cycle(4'b1001, 4'b1000, 1'b1);
    chk("mask_pending_held", int'(bus.pending), 4'b1000);
    cycle(4'b1001, 4'b0000, 1'b0);
    chk("unmask_valid", int'(bus.valid), 1);
    chk("unmask_id", int'(bus.id), 3);
    cycle(4'b0000, 4'b0000, 1'b1);

    // re-request coinciding with ack
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("rereq_id", int'(bus.id), 2);
    cycle(4'b0100, 4'b0000, 1'b1);
    chk("rereq_pending_kept", int'(bus.pending), 4'b0100);
    chk("rereq_valid_drop", int'(bus.valid), 0);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("rereq_regrant", int'(bus.valid), 1);
    chk("rereq_regrant_id", int'(bus.id), 2);
    cycle(4'b0000, 4'b0000, 1'b1);

    // held-high line is not re-pended
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("held_no_repend", int'(bus.pending), 0);
    chk("held_no_grant", int'(bus.valid), 0);

    // asynchronous reset mid-grant
    cycle(4'b1010, 4'b0000, 1'b0);
    cycle(4'b1010, 4'b0000, 1'b0);
    chk("pre_rst_id", int'(bus.id), 3);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_valid", int'(bus.valid), 0);
    chk("async_rst_id", int'(bus.id), 0);
    chk("async_rst_pending", int'(bus.pending), 0);
    cycle(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("post_rst_no_grant", int'(bus.valid), 0);

    // level-high through reset release
    rst_n = 1'b0;
    cycle(4'b0100, 4'b0000, 1'b0);
    rst_n = 1'b1;
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("level_pending", int'(bus.pending), 4'b0100);
    chk("level_valid0", int'(bus.valid), 0);
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("level_id", int'(bus.id), 2);
    chk("level_valid", int'(bus.valid), 1);
    cycle(4'b0100, 4'b0000, 1'b1);

    // randomized traffic checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r;
      logic [N-1:0] m;
      r = ($urandom_range(0, 2) == 0) ? N'($urandom) : bus.req;
      m = ($urandom_range(0, 4) == 0) ? (N'($urandom) & N'($urandom)) : bus.mask;
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cycle(r, m, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
